regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port register file for the LUMOS core, with synchronous (registered) reads, write-first bypass, hardwired-zero register 0 and an integrated busy-bit scoreboard for multicycle hazard tracking. The decode stage reserves a destination on issue and reads operands through it; writeback clears the reservation on write. It replaces the single-cycle asynchronous register file in the operand-fetch path.

## Interface
- WIDTH, 32, data bits per register
- DEPTH, 5, index bits; 2**DEPTH registers
- READ_PORTS, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never reserved

- clk  input  1  core clock, all state on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- read_enable  input  READ_PORTS  per-port read request
- read_index  input  READ_PORTS*DEPTH  per-port index, port p at [p*DEPTH +: DEPTH]
- read_data  output  READ_PORTS*WIDTH  registered read data, port p at [p*WIDTH +: WIDTH]
- read_valid  output  READ_PORTS  registered; read_data[p] carries a hazard-free value
- write_enable  input  1  writeback strobe
- write_index  input  DEPTH  writeback destination
- write_data  input  WIDTH  writeback value
- reserve_enable  input  1  mark destination busy (instruction issue)
- reserve_index  input  DEPTH  destination being reserved
- busy  output  2**DEPTH  current busy bit per register (register output, no combinational path)
- pending_count  output  DEPTH+1  number of busy registers
- write_error  output  1  sticky: write to a non-busy register occurred

## Operation
- Reset: all registers, busy bits, read_data, read_valid, pending_count, write_error cleared to 0. Reset wins over every same-cycle request.
- Write: write_enable stores write_data at write_index and clears its busy bit. With ZERO_REG=1, index 0 is ignored (no store, no error).
- write_error set when write_enable targets a nonzero register whose busy bit is 0 and which is not reserved the same cycle; data is still stored. Cleared only by reset.
- Reserve: reserve_enable sets busy[reserve_index]; index 0 ignored when ZERO_REG=1. Reserving an already-busy register leaves it busy; pending_count unchanged.
- Same-cycle write and reserve of the same index: data stored, busy ends set (new reservation wins), pending_count unchanged.
- Read port p, read_enable[p]=1: hazard if busy[idx]=1 and not cleared by a same-cycle write to idx. Hazard: read_valid[p]<=0, read_data[p] holds. No hazard: read_valid[p]<=1, read_data[p]<= write_data if same-cycle write to idx (bypass), else stored value; index 0 returns 0 when ZERO_REG=1.
- Same-cycle reserve does not affect the read issued in that cycle (read precedes reserve).
- read_enable[p]=0: read_valid[p]<=0, read_data[p] holds. Outputs are never driven to Z.
- pending_count: +1 on reserve of a non-busy register, -1 on write clearing a busy register without same-cycle reserve; both rules applied together, never wraps (max 2**DEPTH, or 2**DEPTH-1 with ZERO_REG).

## Timing
- Read latency 1 cycle: request at edge n, read_data/read_valid valid after edge n+1 until next edge.
- Write and reserve take effect at the edge they are sampled; busy/pending_count reflect them after that edge.
- Bypass is write-first within the same edge; no extra stall cycle.
- First usable cycle: the edge after reset deasserts.

## Structure
- Shared package regfile_pkg: default WIDTH/DEPTH, index and word typedefs, ZERO_INDEX constant.
- Sub-module regfile_busy_table: busy vector, pending_count, write_error and the hazard query per port; the data array and read registers stay in the top.

## Test plan
- Reset then read x5 and x0 on both ports -> next cycle read_valid=2'b11, read_data=0; busy=0, pending_count=0.
- Reserve x3, next cycle read x3 on port 0 -> read_valid[0]=0, pending_count=1; write x3=0xDEADBEEF with same-cycle read x3 -> next cycle read_data[0]=0xDEADBEEF, read_valid[0]=1, pending_count=0.
- Write x0=0x1234 and reserve x0, then read x0 -> read_data=0, busy[0]=0, write_error=0.
- Write x7=0x55 while reserving x7 same cycle -> busy[7]=1, pending_count unchanged, write_error stays 0; later read x7 stalls until next write.
- Write x9=0xA5 with x9 not busy -> write_error=1 and stays 1; read x9 returns 0xA5; reset clears it.
- Reserve x1..x31 sequentially -> pending_count=31 (ZERO_REG=1); assert reset mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helper types for the LUMOS operand-fetch register file.
package regfile_pkg;

   localparam int unsigned DefWidth = 32;
   localparam int unsigned DefDepth = 5;
   localparam int unsigned ZERO_INDEX = 0;

   typedef logic [DefDepth-1:0] reg_idx_t;
   typedef logic [DefWidth-1:0] reg_word_t;

endpackage

// File: rtl/regfile_busy_table.sv
// Busy-bit scoreboard: tracks reserved destinations, their count, misuse of writeback,
// and answers per-port hazard queries against the state before the current edge.
module regfile_busy_table
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH      = DefDepth,
   parameter int unsigned READ_PORTS = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        write_enable_i,
   input  logic [DEPTH-1:0]            write_index_i,
   input  logic                        reserve_enable_i,
   input  logic [DEPTH-1:0]            reserve_index_i,
   input  logic [READ_PORTS*DEPTH-1:0] query_index_i,
   output logic [READ_PORTS-1:0]       hazard_o,
   output logic [2**DEPTH-1:0]         busy_o,
   output logic [DEPTH:0]              pending_count_o,
   output logic                        write_error_o
);

   localparam bit HasZero = (ZERO_REG != 0);

   logic [2**DEPTH-1:0] busy_q, busy_d;
   logic [DEPTH:0]      pending_q, pending_d;
   logic                error_q, error_d;
   logic                wr_eff, rs_eff, same_idx, inc, dec;

   assign wr_eff   = write_enable_i && !(HasZero && write_index_i == DEPTH'(ZERO_INDEX));
   assign rs_eff   = reserve_enable_i && !(HasZero && reserve_index_i == DEPTH'(ZERO_INDEX));
   assign same_idx = rs_eff && (reserve_index_i == write_index_i);
   assign inc      = rs_eff && !busy_q[reserve_index_i];
   assign dec      = wr_eff && busy_q[write_index_i] && !same_idx;

   always_comb begin
      busy_d    = busy_q;
      pending_d = pending_q;
      error_d   = error_q;
      if (wr_eff) begin
         busy_d[write_index_i] = 1'b0;
         if (!busy_q[write_index_i] && !same_idx) begin
            error_d = 1'b1;
         end
      end
      // Reservation is applied last so a same-cycle reserve wins over the clear.
      if (rs_eff) begin
         busy_d[reserve_index_i] = 1'b1;
      end
      unique case ({inc, dec})
         2'b10:   pending_d = pending_q + 1'b1;
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase
   end

   always_comb begin
      hazard_o = '0;
      for (int p = 0; p < int'(READ_PORTS); p++) begin
         hazard_o[p] = busy_q[query_index_i[p*DEPTH +: DEPTH]] &&
                       !(wr_eff && write_index_i == query_index_i[p*DEPTH +: DEPTH]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_q    <= '0;
         pending_q <= '0;
         error_q   <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
         error_q   <= error_d;
      end
   end

   assign busy_o          = busy_q;
   assign pending_count_o = pending_q;
   assign write_error_o   = error_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with registered reads, write-first bypass, optional hardwired
// zero register and an integrated busy-bit scoreboard for multicycle hazard tracking.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned DEPTH      = DefDepth,
   parameter int unsigned READ_PORTS = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [READ_PORTS-1:0]       read_enable_i,
   input  logic [READ_PORTS*DEPTH-1:0] read_index_i,
   output logic [READ_PORTS*WIDTH-1:0] read_data_o,
   output logic [READ_PORTS-1:0]       read_valid_o,
   input  logic                        write_enable_i,
   input  logic [DEPTH-1:0]            write_index_i,
   input  logic [WIDTH-1:0]            write_data_i,
   input  logic                        reserve_enable_i,
   input  logic [DEPTH-1:0]            reserve_index_i,
   output logic [2**DEPTH-1:0]         busy_o,
   output logic [DEPTH:0]              pending_count_o,
   output logic                        write_error_o
);

   localparam int unsigned NumRegs = 2**DEPTH;
   localparam bit          HasZero = (ZERO_REG != 0);

   logic [WIDTH-1:0]            regs_q [NumRegs];
   logic [READ_PORTS*WIDTH-1:0] rd_data_q, rd_data_d;
   logic [READ_PORTS-1:0]       rd_valid_q, rd_valid_d;
   logic [READ_PORTS-1:0]       hazard;
   logic                        wr_eff;
   logic [DEPTH-1:0]            ridx;

   assign wr_eff = write_enable_i && !(HasZero && write_index_i == DEPTH'(ZERO_INDEX));

   regfile_busy_table #(
      .DEPTH      (DEPTH),
      .READ_PORTS (READ_PORTS),
      .ZERO_REG   (ZERO_REG)
   ) u_busy_table (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .write_enable_i   (write_enable_i),
      .write_index_i    (write_index_i),
      .reserve_enable_i (reserve_enable_i),
      .reserve_index_i  (reserve_index_i),
      .query_index_i    (read_index_i),
      .hazard_o         (hazard),
      .busy_o           (busy_o),
      .pending_count_o  (pending_count_o),
      .write_error_o    (write_error_o)
   );

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = '0;
      ridx       = '0;
      for (int p = 0; p < int'(READ_PORTS); p++) begin
         ridx = read_index_i[p*DEPTH +: DEPTH];
         if (read_enable_i[p] && !hazard[p]) begin
            rd_valid_d[p] = 1'b1;
            if (HasZero && ridx == DEPTH'(ZERO_INDEX)) begin
               rd_data_d[p*WIDTH +: WIDTH] = '0;
            end else if (wr_eff && write_index_i == ridx) begin
               rd_data_d[p*WIDTH +: WIDTH] = write_data_i;
            end else begin
               rd_data_d[p*WIDTH +: WIDTH] = regs_q[ridx];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < int'(NumRegs); i++) begin
            regs_q[i] <= '0;
         end
         rd_data_q  <= '0;
         rd_valid_q <= '0;
      end else begin
         if (wr_eff) begin
            regs_q[write_index_i] <= write_data_i;
         end
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign read_data_o  = rd_data_q;
   assign read_valid_o = rd_valid_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios then random traffic,
// checked against a rule-level reference model through an expectation queue.
module tb_regfile_scoreboard;

   localparam int W = 32;
   localparam int D = 5;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    read_enable;
   logic [2*D-1:0] read_index;
   logic [2*W-1:0] read_data;
   logic [1:0]    read_valid;
   logic          write_enable;
   logic [D-1:0]  write_index;
   logic [W-1:0]  write_data;
   logic          reserve_enable;
   logic [D-1:0]  reserve_index;
   logic [N-1:0]  busy;
   logic [D:0]    pending_count;
   logic          write_error;

   regfile_scoreboard #(
      .WIDTH      (W),
      .DEPTH      (D),
      .READ_PORTS (2),
      .ZERO_REG   (1)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .read_enable_i    (read_enable),
      .read_index_i     (read_index),
      .read_data_o      (read_data),
      .read_valid_o     (read_valid),
      .write_enable_i   (write_enable),
      .write_index_i    (write_index),
      .write_data_i     (write_data),
      .reserve_enable_i (reserve_enable),
      .reserve_index_i  (reserve_index),
      .busy_o           (busy),
      .pending_count_o  (pending_count),
      .write_error_o    (write_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]     rv;
      logic [2*W-1:0] rd;
      logic [N-1:0]   busy;
      logic [D:0]     pend;
      logic           err;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model state
   logic [W-1:0] m_regs [N];
   bit           m_busy [N];
   bit           m_err;
   logic [W-1:0] m_rd [2];
   bit           m_rv [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Applies one cycle of the architectural rules: reads see pre-edge state plus bypass,
   // then writeback, then reservation.
   task automatic model_step(input bit rst, input logic [1:0] re, input int ri0, input int ri1,
                             input bit we, input int wi, input logic [W-1:0] wd,
                             input bit rse, input int rsi);
      int  ri [2];
      bit  wr, rs;
      exp_t e;
      ri[0] = ri0;
      ri[1] = ri1;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
         end
         m_err = 0;
         for (int p = 0; p < 2; p++) begin
            m_rd[p] = '0;
            m_rv[p] = 0;
         end
      end else begin
         wr = we && (wi != 0);
         rs = rse && (rsi != 0);
         for (int p = 0; p < 2; p++) begin
            if (!re[p]) begin
               m_rv[p] = 0;
            end else if (m_busy[ri[p]] && !(wr && wi == ri[p])) begin
               m_rv[p] = 0;
            end else begin
               m_rv[p] = 1;
               if (ri[p] == 0) m_rd[p] = '0;
               else if (wr && wi == ri[p]) m_rd[p] = wd;
               else m_rd[p] = m_regs[ri[p]];
            end
         end
         if (wr) begin
            if (!m_busy[wi] && !(rs && rsi == wi)) m_err = 1;
            m_regs[wi] = wd;
            m_busy[wi] = 0;
         end
         if (rs) m_busy[rsi] = 1;
      end
      e.rv   = {m_rv[1], m_rv[0]};
      e.rd   = {m_rd[1], m_rd[0]};
      e.err  = m_err;
      e.busy = '0;
      e.pend = '0;
      for (int i = 0; i < N; i++) begin
         e.busy[i] = m_busy[i];
         e.pend    = e.pend + (m_busy[i] ? 1 : 0);
      end
      q.push_back(e);
   endtask

   task automatic cyc(input bit rst, input logic [1:0] re, input int ri0, input int ri1,
                      input bit we, input int wi, input logic [W-1:0] wd,
                      input bit rse, input int rsi);
      @(negedge clk);
      reset          = rst;
      read_enable    = re;
      read_index     = {D'(ri1), D'(ri0)};
      write_enable   = we;
      write_index    = D'(wi);
      write_data     = wd;
      reserve_enable = rse;
      reserve_index  = D'(rsi);
      model_step(rst, re, ri0, ri1, we, wi, wd, rse, rsi);
   endtask

   task automatic idle();
      cyc(0, 2'b00, 0, 0, 0, 0, '0, 0, 0);
   endtask

   // Monitor: pops one expectation per edge once traffic has been issued.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("read_valid", 64'(read_valid), 64'(e.rv));
            if (e.rv[0]) chk("read_data0", 64'(read_data[W-1:0]), 64'(e.rd[W-1:0]));
            if (e.rv[1]) chk("read_data1", 64'(read_data[2*W-1:W]), 64'(e.rd[2*W-1:W]));
            chk("read_data_all", read_data, e.rd);
            chk("busy", 64'(busy), 64'(e.busy));
            chk("pending_count", 64'(pending_count), 64'(e.pend));
            chk("write_error", 64'(write_error), 64'(e.err));
         end
      end
   end

   initial begin
      int wi, rsi, k, wait_cnt;
      reset = 1'b1;
      read_enable = '0;
      read_index = '0;
      write_enable = 1'b0;
      write_index = '0;
      write_data = '0;
      reserve_enable = 1'b0;
      reserve_index = '0;

      cyc(1, 2'b00, 0, 0, 0, 0, '0, 0, 0);
      cyc(1, 2'b00, 0, 0, 0, 0, '0, 0, 0);
      // Post-reset reads of x5 and x0 on both ports
      cyc(0, 2'b11, 5, 0, 0, 0, '0, 0, 0);
      cyc(0, 2'b11, 0, 5, 0, 0, '0, 0, 0);
      // Reserve x3, stalled read, then write with bypass
      cyc(0, 2'b00, 0, 0, 0, 0, '0, 1, 3);
      cyc(0, 2'b01, 3, 0, 0, 0, '0, 0, 0);
      cyc(0, 2'b11, 3, 3, 1, 3, 32'hDEADBEEF, 0, 0);
      cyc(0, 2'b11, 3, 3, 0, 0, '0, 0, 0);
      // Zero register ignores write and reserve
      cyc(0, 2'b00, 0, 0, 1, 0, 32'h1234, 1, 0);
      cyc(0, 2'b11, 0, 0, 0, 0, '0, 0, 0);
      // Write and reserve x7 together, then stall until the next write
      cyc(0, 2'b00, 0, 0, 0, 0, '0, 1, 7);
      cyc(0, 2'b00, 0, 0, 1, 7, 32'h55, 1, 7);
      cyc(0, 2'b01, 7, 0, 0, 0, '0, 0, 0);
      cyc(0, 2'b10, 0, 7, 0, 0, '0, 0, 0);
      cyc(0, 2'b00, 0, 0, 1, 7, 32'h66, 0, 0);
      cyc(0, 2'b11, 7, 7, 0, 0, '0, 0, 0);
      // Write to a non-busy register raises the sticky error
      cyc(0, 2'b00, 0, 0, 1, 9, 32'hA5, 0, 0);
      cyc(0, 2'b01, 9, 0, 0, 0, '0, 0, 0);
      idle();
      cyc(1, 2'b00, 0, 0, 0, 0, '0, 0, 0);
      cyc(0, 2'b01, 9, 0, 0, 0, '0, 0, 0);
      // Fill the scoreboard, then reset mid-way through a second fill
      for (int i = 1; i < N; i++) cyc(0, 2'b00, 0, 0, 0, 0, '0, 1, i);
      idle();
      for (int i = 1; i < 10; i++) cyc(0, 2'b00, 0, 0, 0, 0, '0, 1, i);
      cyc(1, 2'b11, 3, 4, 1, 5, 32'hFFFF, 1, 6);
      idle();

      // Random traffic, writes biased toward busy registers
      for (int c = 0; c < 600; c++) begin
         wi = $urandom_range(N - 1);
         if ($urandom_range(3) != 0) begin
            for (int j = 0; j < N; j++) begin
               k = (wi + j) % N;
               if (m_busy[k]) begin
                  wi = k;
                  break;
               end
            end
         end
         rsi = $urandom_range(N - 1);
         if ($urandom_range(15) == 0) rsi = wi;
         cyc(($urandom_range(79) == 0), 2'($urandom_range(3)),
             $urandom_range(N - 1), $urandom_range(N - 1),
             $urandom_range(1), wi, $urandom, $urandom_range(1), rsi);
      end
      idle();

      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain actual=%0d required=0 expectations left", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
